// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared datapath constants and helpers
package mips_pkg;

    localparam int WORD_W = 32;

    localparam int FWD_REG   = 0;
    localparam int FWD_EXMEM = 1;
    localparam int FWD_MEMWB = 2;
    localparam int FWD_IMM   = 3;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/mux_n_comb.sv
// rtl/mux_n_comb.sv - combinational N-way binary-select mux with range flag
module mux_n_comb
    import mips_pkg::*;
#(
    parameter int WIDTH  = WORD_W,
    parameter int NUM_IN = 4,
    localparam int SEL_W = clog2(NUM_IN)
) (
    input  logic [NUM_IN*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        data_sel,
    output logic                    range_ok
);

    // range_ok falls out of the match itself, so codes past NUM_IN select nothing
    always_comb begin
        data_sel = '0;
        range_ok = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (int'(sel) == i) begin
                data_sel = data_in[i*WIDTH +: WIDTH];
                range_ok = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_pipe_n.sv
// rtl/mux_pipe_n.sv - registered N-way select stage with stall, flush, valid and sticky select error
module mux_pipe_n
    import mips_pkg::*;
#(
    parameter int               WIDTH        = WORD_W,
    parameter int               NUM_IN       = 4,
    localparam int              SEL_W        = clog2(NUM_IN),
    parameter logic [WIDTH-1:0] RESET_VAL    = '0,
    parameter bit               HOLD_ON_IDLE = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    input  logic                    stall,
    input  logic                    flush,
    input  logic                    err_clr,
    output logic [WIDTH-1:0]        data_out,
    output logic                    out_valid,
    output logic [SEL_W-1:0]        sel_q,
    output logic                    sel_err
);

    logic [WIDTH-1:0] data_sel;
    logic             range_ok;
    logic             load;
    logic             err_set;

    mux_n_comb #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN)
    ) u_mux (
        .data_in  (data_in),
        .sel      (sel),
        .data_sel (data_sel),
        .range_ok (range_ok)
    );

    assign load    = !flush && !stall;
    // bubbles are not range-checked; only a real instruction can raise the error
    assign err_set = load && in_valid && !range_ok;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out  <= RESET_VAL;
            out_valid <= 1'b0;
            sel_q     <= '0;
        end else if (flush) begin
            data_out  <= RESET_VAL;
            out_valid <= 1'b0;
            sel_q     <= '0;
        end else if (load) begin
            sel_q     <= sel;
            out_valid <= in_valid;
            if (in_valid) begin
                data_out <= range_ok ? data_sel : RESET_VAL;
            end else if (!HOLD_ON_IDLE) begin
                data_out <= RESET_VAL;
            end
        end
    end

    // set beats clear when both land on the same edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_err <= 1'b0;
        end else if (err_set) begin
            sel_err <= 1'b1;
        end else if (err_clr) begin
            sel_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_pipe_n.sv
// tb/tb_mux_pipe_n.sv - directed and model-checked bench for mux_pipe_n
module tb_mux_pipe_n;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // instance a: defaults (32-bit, 4 inputs, hold on idle, reset value 0)
    logic [127:0] a_data;
    logic [1:0]   a_sel, a_selq;
    logic         a_valid, a_stall, a_flush, a_clr, a_ovalid, a_err;
    logic [31:0]  a_out;

    // instance b: 3 inputs of 8 bits
    logic [23:0]  b_data;
    logic [1:0]   b_sel, b_selq;
    logic         b_valid, b_stall, b_flush, b_clr, b_ovalid, b_err;
    logic [7:0]   b_out;

    // instance c: load reset value on idle, reset value all ones
    logic [127:0] c_data;
    logic [1:0]   c_sel, c_selq;
    logic         c_valid, c_stall, c_flush, c_clr, c_ovalid, c_err;
    logic [31:0]  c_out;

    // instance d: 16 inputs of 5 bits
    logic [79:0]  d_data;
    logic [3:0]   d_sel, d_selq;
    logic         d_valid, d_stall, d_flush, d_clr, d_ovalid, d_err;
    logic [4:0]   d_out;

    mux_pipe_n u_a (
        .clk(clk), .rst_n(rst_n), .data_in(a_data), .sel(a_sel), .in_valid(a_valid),
        .stall(a_stall), .flush(a_flush), .err_clr(a_clr), .data_out(a_out),
        .out_valid(a_ovalid), .sel_q(a_selq), .sel_err(a_err)
    );

    mux_pipe_n #(.WIDTH(8), .NUM_IN(3)) u_b (
        .clk(clk), .rst_n(rst_n), .data_in(b_data), .sel(b_sel), .in_valid(b_valid),
        .stall(b_stall), .flush(b_flush), .err_clr(b_clr), .data_out(b_out),
        .out_valid(b_ovalid), .sel_q(b_selq), .sel_err(b_err)
    );

    mux_pipe_n #(.RESET_VAL(32'hFFFF_FFFF), .HOLD_ON_IDLE(1'b0)) u_c (
        .clk(clk), .rst_n(rst_n), .data_in(c_data), .sel(c_sel), .in_valid(c_valid),
        .stall(c_stall), .flush(c_flush), .err_clr(c_clr), .data_out(c_out),
        .out_valid(c_ovalid), .sel_q(c_selq), .sel_err(c_err)
    );

    mux_pipe_n #(.WIDTH(5), .NUM_IN(16)) u_d (
        .clk(clk), .rst_n(rst_n), .data_in(d_data), .sel(d_sel), .in_valid(d_valid),
        .stall(d_stall), .flush(d_flush), .err_clr(d_clr), .data_out(d_out),
        .out_valid(d_ovalid), .sel_q(d_selq), .sel_err(d_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [4:0] m_data;
    logic       m_valid;
    logic [3:0] m_sel;

    initial begin
        rst_n = 1'b0;
        a_data = '0; a_sel = '0; a_valid = 0; a_stall = 0; a_flush = 0; a_clr = 0;
        b_data = '0; b_sel = '0; b_valid = 0; b_stall = 0; b_flush = 0; b_clr = 0;
        c_data = '0; c_sel = '0; c_valid = 0; c_stall = 0; c_flush = 0; c_clr = 0;
        d_data = '0; d_sel = '0; d_valid = 0; d_stall = 0; d_flush = 0; d_clr = 0;
        step();
        step();
        chk("rst a_out",   a_out,    0);
        chk("rst a_valid", a_ovalid, 0);
        chk("rst a_selq",  a_selq,   0);
        chk("rst a_err",   a_err,    0);
        chk("rst c_out",   c_out,    32'hFFFF_FFFF);
        chk("rst d_out",   d_out,    0);
        rst_n = 1'b1;

        // basic select sweep
        a_data = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        a_valid = 1'b1;
        for (int s = 0; s < 4; s++) begin
            a_sel = 2'(s);
            step();
            chk($sformatf("sweep out %0d", s),   a_out,    32'h1111_1111 * (s + 1));
            chk($sformatf("sweep valid %0d", s), a_ovalid, 1);
            chk($sformatf("sweep selq %0d", s),  a_selq,   s);
        end

        // stall hold then flush beating stall
        a_data[31:0] = 32'hDEAD_BEEF;
        a_sel = 2'd0;
        step();
        chk("load deadbeef", a_out, 32'hDEAD_BEEF);
        a_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a_data = {4{32'h0BAD_0000 + 32'(k)}};
            a_sel = 2'(k + 1);
            a_valid = k[0];
            step();
            chk($sformatf("stall out %0d", k),   a_out,    32'hDEAD_BEEF);
            chk($sformatf("stall valid %0d", k), a_ovalid, 1);
            chk($sformatf("stall selq %0d", k),  a_selq,   0);
        end
        a_flush = 1'b1;
        step();
        chk("flush out",   a_out,    0);
        chk("flush valid", a_ovalid, 0);
        chk("flush selq",  a_selq,   0);
        a_flush = 1'b0; a_stall = 1'b0;

        // idle behaviour, hold vs reload
        a_data = {96'h0, 32'h1234_5678}; a_sel = 2'd0; a_valid = 1'b1;
        c_data = {96'h0, 32'h1234_5678}; c_sel = 2'd0; c_valid = 1'b1;
        step();
        chk("idle a load", a_out, 32'h1234_5678);
        chk("idle c load", c_out, 32'h1234_5678);
        a_valid = 1'b0; a_sel = 2'd2;
        c_valid = 1'b0; c_sel = 2'd2;
        step();
        chk("idle a out",   a_out,    32'h1234_5678);
        chk("idle a valid", a_ovalid, 0);
        chk("idle a selq",  a_selq,   2);
        chk("idle c out",   c_out,    32'hFFFF_FFFF);
        chk("idle c valid", c_ovalid, 0);

        // out-of-range select on a 3-input stage
        b_data = {8'hA3, 8'hA2, 8'hA1};
        b_sel = 2'd3; b_valid = 1'b1; b_stall = 1'b1;
        step();
        chk("stall no err", b_err, 0);
        b_stall = 1'b0;
        step();
        chk("bad sel out",   b_out,    8'h00);
        chk("bad sel valid", b_ovalid, 1);
        chk("bad sel err",   b_err,    1);
        chk("bad sel selq",  b_selq,   3);
        b_clr = 1'b1;
        step();
        chk("set beats clr", b_err, 1);
        b_clr = 1'b0; b_flush = 1'b1;
        step();
        chk("flush keeps err", b_err, 1);
        b_flush = 1'b0; b_clr = 1'b1; b_sel = 2'd0;
        step();
        chk("clr err", b_err, 0);
        chk("clr out", b_out, 8'hA1);
        b_clr = 1'b0;
        b_valid = 1'b0; b_sel = 2'd3;
        step();
        chk("idle bad sel no err", b_err, 0);

        // reset in mid-stream
        b_sel = 2'd3; b_valid = 1'b1;
        step();
        chk("err before rst", b_err, 1);
        a_data = {32'h0, 32'hCAFE_F00D, 32'h0, 32'h0};
        a_sel = 2'd2; a_valid = 1'b1;
        b_valid = 1'b0;
        rst_n = 1'b0;
        step();
        chk("mid rst out",   a_out,    0);
        chk("mid rst valid", a_ovalid, 0);
        chk("mid rst selq",  a_selq,   0);
        chk("mid rst b err", b_err,    0);
        rst_n = 1'b1;
        step();
        chk("post rst out",   a_out,    32'hCAFE_F00D);
        chk("post rst valid", a_ovalid, 1);
        chk("post rst selq",  a_selq,   2);

        // 16-input stage against a reference model
        m_data = '0; m_valid = 1'b0; m_sel = '0;
        for (int n = 0; n < 1000; n++) begin
            for (int i = 0; i < 16; i++) d_data[i*5 +: 5] = 5'($urandom);
            d_sel   = 4'($urandom);
            d_valid = ($urandom_range(0, 3) != 0);
            d_stall = ($urandom_range(0, 3) == 0);
            d_flush = ($urandom_range(0, 7) == 0);
            d_clr   = ($urandom_range(0, 7) == 0);
            if (d_flush) begin
                m_data = '0; m_valid = 1'b0; m_sel = '0;
            end else if (!d_stall) begin
                m_valid = d_valid;
                m_sel = d_sel;
                if (d_valid) m_data = d_data[d_sel*5 +: 5];
            end
            step();
            chk("rand out",   d_out,    m_data);
            chk("rand valid", d_ovalid, m_valid);
            chk("rand selq",  d_selq,   m_sel);
            chk("rand err",   d_err,    0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_pipe_n.md
Name: mux_pipe_n

Overview:
- Parametrised N-input, W-bit select stage with a registered output, for the pipelined datapath.
- Used for forwarding, ALU-source and write-back selection at pipeline-register boundaries.
- Supports stall (hold), flush (bubble), valid tracking, and sticky detection of out-of-range selects.
- Generalises the fixed 4:1 32-bit combinational mux.

Parameters:
- WIDTH, 32, data width of each input and of the output.
- NUM_IN, 4, number of data inputs; legal range 2..16; need not be a power of two.
- SEL_W, clog2(NUM_IN), select width; derived, never overridden.
- RESET_VAL, 0, value loaded into data_out on reset, on flush and on an illegal select.
- HOLD_ON_IDLE, 1, when in_valid=0: 1 = data_out holds its value; 0 = data_out loads RESET_VAL.

Ports:
- clk  in  1  rising-edge clock; single clock domain.
- rst_n  in  1  synchronous, active-low reset.
- data_in  in  NUM_IN*WIDTH  flattened inputs; input i occupies bits [i*WIDTH +: WIDTH].
- sel  in  SEL_W  binary select.
- in_valid  in  1  the current input set is a real instruction, not a bubble.
- stall  in  1  hold all registered state.
- flush  in  1  replace the stage contents with a bubble.
- err_clr  in  1  clear sel_err.
- data_out  out  WIDTH  registered selected data.
- out_valid  out  1  data_out carries a valid instruction result.
- sel_q  out  SEL_W  select value captured with data_out; for debug and hazard visibility.
- sel_err  out  1  sticky flag: an out-of-range select was loaded.

Behaviour:
- Latency is 1 cycle: inputs sampled at edge k appear on the outputs after edge k.
- There is no combinational path from any input to any output.
- Reset: when rst_n=0 at the edge, data_out=RESET_VAL, out_valid=0, sel_q=0, sel_err=0.
- Priority per edge is reset > flush > stall > load.
- Flush: data_out=RESET_VAL, out_valid=0, sel_q=0. sel_err is unchanged except by err_clr.
- Flush with stall in the same cycle: flush wins.
- Stall (without flush): data_out, out_valid and sel_q hold. sel_err is not set; err_clr still applies.
- Load, in_valid=1, sel < NUM_IN: data_out = input[sel], out_valid=1, sel_q=sel.
- Load, in_valid=1, sel >= NUM_IN (possible only if NUM_IN is not a power of two): data_out=RESET_VAL, out_valid=1, sel_q=sel, sel_err set to 1.
- Load, in_valid=0: out_valid=0 and sel_q=sel. data_out holds if HOLD_ON_IDLE=1, else loads RESET_VAL. sel is not range-checked.
- err_clr=1 clears sel_err at the edge.
- A new error and err_clr in the same cycle: the set wins, so sel_err=1.
- Reset deasserting mid-operation: the first load happens on the first edge with rst_n=1. There are no residual pipeline contents.
- Selects are binary only; there is no one-hot or priority encoding.
- Width rules: no arithmetic, no truncation, no sign extension; bits pass through unchanged.

Decomposition:
- Shared package mips_pkg holds:
  - the clog2 constant function;
  - WORD_W=32;
  - localparams for the standard 4-way forwarding encodings: FWD_REG=0, FWD_EXMEM=1, FWD_MEMWB=2, FWD_IMM=3.
- Sub-module mux_n_comb: purely combinational. Takes WIDTH, NUM_IN, flattened data_in and sel. Produces the selected word and a range_ok flag.
- mux_pipe_n instantiates one mux_n_comb plus the output register and error logic.

Test Plan:
1. Defaults; data_in = {4,3,2,1}×0x11111111 (input i = (i+1)×0x11111111); sel sweeps 0..3 with in_valid=1 -> data_out one cycle later is 0x11111111, 0x22222222, 0x33333333, 0x44444444; out_valid=1; sel_q tracks sel.
2. Load 0xDEADBEEF, then stall=1 for 3 cycles while data_in and sel change -> data_out stays 0xDEADBEEF and out_valid=1 for all 3 cycles. Then flush=1 with stall=1 -> data_out=0, out_valid=0 next cycle.
3. NUM_IN=3, WIDTH=8: sel=3 with in_valid=1 -> data_out=0x00, out_valid=1, sel_err=1. Then err_clr=1 with sel=3 on the same edge -> sel_err stays 1. err_clr=1 with sel=0 -> sel_err=0.
4. HOLD_ON_IDLE=0, RESET_VAL=0xFFFFFFFF: after loading 0x12345678, drive in_valid=0 -> data_out=0xFFFFFFFF, out_valid=0. With HOLD_ON_IDLE=1, the same stimulus -> data_out stays 0x12345678, out_valid=0.
5. Reset mid-stream: rst_n=0 for one edge while in_valid=1 and sel=2 -> data_out=RESET_VAL, out_valid=0, sel_q=0, sel_err=0. The first edge after release loads input[2].
6. NUM_IN=16, WIDTH=5: random sel and data for 1000 cycles with random stall/flush, checked against a reference model -> zero mismatches; sel_err never asserts.
